confirm_input_ctrl: RTL

Sequences CPU input from the board switches: debounces the confirm push-button, captures a stable snapshot of the 16 switches on each accepted press, and raises a confirmation flag for the CPU to poll through the memory-mapped input path. The CPU clears the flag by reading one of the switch data addresses, so each press is consumed exactly once. The block sits between the raw board pins and the switch I/O read multiplexer. The multiplexer takes `confirmation` and `switchLatched` from this block instead of the live pins.

---
 rtl/confirm_input_ctrl_if.sv | 20 ++
 rtl/confirm_input_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/confirm_input_ctrl_if.sv
// confirm_input_ctrl_if: board pins, CPU load strobe and confirm/snapshot outputs of the confirm-input block
interface confirm_input_ctrl_if;
    logic        btnRaw;
    logic [15:0] switchRaw;
    logic        ioRead;
    logic        switchCtrl;
    logic [31:0] address;
    logic        confirmation;
    logic        overrun;
    logic [15:0] switchLatched;
    logic        busy;
    modport slave (
        input  btnRaw, switchRaw, ioRead, switchCtrl, address,
        output confirmation, overrun, switchLatched, busy
    );
    modport master (
        output btnRaw, switchRaw, ioRead, switchCtrl, address,
        input  confirmation, overrun, switchLatched, busy
    );
endinterface

// File: rtl/confirm_input_ctrl.sv
// confirm_input_ctrl: debounces the confirm button, snapshots switches per press, read-to-clear flag
module confirm_input_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 20
) (
    input logic                 clk,
    input logic                 rst,
    confirm_input_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, sync_q;
    logic             conf_q, conf_d, ovr_q, ovr_d;
    logic [15:0]      snap_q, snap_d;
    logic             accept, consume, cnt_done;
    assign cnt_done = cnt_q == CNT_MAX;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = sync_q ? DEB_PRESS : IDLE;
                cnt_d   = '0;
            end
            DEB_PRESS: begin
                state_d = !sync_q ? IDLE : (cnt_done ? HELD : DEB_PRESS);
                accept  = sync_q && cnt_done;
                cnt_d   = cnt_q + 1'b1;
            end
            HELD: begin
                state_d = sync_q ? HELD : DEB_RELEASE;
                cnt_d   = '0;
            end
            DEB_RELEASE: begin
                state_d = sync_q ? HELD : (cnt_done ? IDLE : DEB_RELEASE);
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // only data addresses consume; the FF00 status poll never does
    assign consume = bus.ioRead && bus.switchCtrl && conf_q &&
                     (bus.address inside {32'hFFFF_FFF1, 32'hFFFF_FFF3, 32'hFFFF_FFF5,
                                          32'hFFFF_FFF7, 32'hFFFF_FFF9});
    // accept beats a same-edge consume
    assign conf_d = accept || (conf_q && !consume);
    assign ovr_d  = accept ? (ovr_q || conf_q) : (ovr_q && !consume);
    assign snap_d = accept ? bus.switchRaw : snap_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            sync_q  <= 1'b0;
            conf_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= bus.btnRaw;
            sync_q  <= s1_q;
            conf_q  <= conf_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end
    assign bus.confirmation  = conf_q;
    assign bus.overrun       = ovr_q;
    assign bus.switchLatched = snap_q;
    assign bus.busy          = state_q != IDLE;
endmodule
